// File: rtl/sw_pkg.sv
// ---------------------------------------------------------------------------
// sw_pkg
//
// Shared constants, types and helpers for the Smith-Waterman stripe
// sequencer that feeds PE_array_64.
//
// Contents:
//   NUM_PE, SEQ_LEN, NUM_STRIPES, TIMEOUT_CYC  - geometry / watchdog limit
//   STRIPE_W, TMO_W                            - derived counter widths
//   base_t, score_t, pos_t, spos_t             - datapath types
//   seq_state_e                                - sequencer FSM encoding
//   sat_add()                                  - saturating start-position add
// ---------------------------------------------------------------------------
package sw_pkg;

    localparam int NUM_PE      = 64;
    localparam int SEQ_LEN     = 1024;
    localparam int NUM_STRIPES = SEQ_LEN / NUM_PE;
    localparam int TIMEOUT_CYC = 256;

    localparam int STRIPE_W = $clog2(NUM_STRIPES);
    // One spare bit so the counter can represent TIMEOUT_CYC itself.
    localparam int TMO_W    = $clog2(TIMEOUT_CYC) + 1;

    typedef logic [1:0]  base_t;
    typedef logic [13:0] score_t;
    typedef logic [9:0]  pos_t;
    // Absolute start position needs one extra bit: it may equal SEQ_LEN,
    // which is the "reference exhausted" marker.
    typedef logic [10:0] spos_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_B   = 3'd1,
        ST_SETTLE   = 3'd2,
        ST_STREAM   = 3'd3,
        ST_WAIT_END = 3'd4,
        ST_NEXT     = 3'd5,
        ST_DONE     = 3'd6
    } seq_state_e;

    // Advance the absolute start position by the array's relative offset,
    // clamping at SEQ_LEN so the run can terminate cleanly.
    function automatic spos_t sat_add(input spos_t cur, input pos_t rel);
        logic [11:0] sum;
        sum = {1'b0, cur} + {2'b00, rel};
        if (sum > 12'(SEQ_LEN)) begin
            return spos_t'(SEQ_LEN);
        end
        return sum[10:0];
    endfunction

endpackage

// File: rtl/sw_stripe_sequencer.sv
// ---------------------------------------------------------------------------
// sw_stripe_sequencer
//
// Upstream control stage for PE_array_64. Runs a complete Smith-Waterman
// pass over two 2-bit encoded sequences held in external sync-read
// memories: per stripe it loads NUM_PE query bases (B) into the array,
// streams reference bases (A) from the current start position until the
// array raises stripe-end, accumulates the start position and tracks the
// best stripe score.
//
// Optional feature macro: SW_STRIPE_TIMEOUT_EN
//   defined   - watchdog counts STREAM/WAIT_END cycles of a stripe; on
//               reaching TIMEOUT_CYC without stripe-end it sets the sticky
//               o_error and ends the run with an o_done pulse.
//   undefined - no watchdog, o_error tied 0, WAIT_END waits indefinitely.
//
// Ports:
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_go               start-run pulse, ignored while o_busy
//   o_busy             run in progress
//   o_done             one-cycle pulse at end of run
//   o_max_score        best stripe score of the run
//   o_max_stripe       stripe index of o_max_score
//   o_error            watchdog abort flag
//   o_a_addr/i_a_data  A memory read port, data one cycle after address
//   o_b_addr/i_b_data  B memory row port, data one cycle after address
//   o_pe_start         to array i_start
//   o_pe_a             to array i_A
//   o_pe_b             to array i_B, held for a whole stripe
//   i_pe_stripe_end    from array o_stripe_end
//   i_pe_start_pos     from array o_start_position (relative offset)
//   i_pe_max_score     from array o_max_score_stripe
//   o_dbg_state        current FSM state (seq_state_e encoding)
//
// Handshake: there is no back-pressure. A base is transferred to the array
// in every cycle where o_pe_start is 1; the array ends a stripe by holding
// i_pe_stripe_end high for the cycle in which its start_pos/score are valid,
// and the sequencer consumes that cycle unconditionally.
// ---------------------------------------------------------------------------
module sw_stripe_sequencer
    import sw_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_go,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [13:0]           o_max_score,
    output logic [STRIPE_W-1:0]   o_max_stripe,
    output logic                  o_error,
    output logic [9:0]            o_a_addr,
    input  logic [1:0]            i_a_data,
    output logic [STRIPE_W-1:0]   o_b_addr,
    input  logic [2*NUM_PE-1:0]   i_b_data,
    output logic                  o_pe_start,
    output logic [1:0]            o_pe_a,
    output logic [2*NUM_PE-1:0]   o_pe_b,
    input  logic                  i_pe_stripe_end,
    input  logic [9:0]            i_pe_start_pos,
    input  logic [13:0]           i_pe_max_score,
    output logic [2:0]            o_dbg_state
);

    localparam pos_t                A_LAST    = pos_t'(SEQ_LEN - 1);
    localparam spos_t               SPOS_END  = spos_t'(SEQ_LEN);
    localparam logic [STRIPE_W-1:0] K_LAST    = STRIPE_W'(NUM_STRIPES - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    seq_state_e             state_q,      state_d;
    logic                   busy_q,       busy_d;
    logic                   done_q,       done_d;
    score_t                 max_score_q,  max_score_d;
    logic [STRIPE_W-1:0]    max_stripe_q, max_stripe_d;
    logic [STRIPE_W-1:0]    k_q,          k_d;
    spos_t                  start_pos_q,  start_pos_d;
    pos_t                   a_ptr_q,      a_ptr_d;
    // Stage 1 of the valid pipe: a read was issued last cycle, so i_a_data
    // holds a live base this cycle.
    logic                   v1_q,         v1_d;
    // Stage 2: registered base and start strobe presented to the array.
    logic                   pe_start_q,   pe_start_d;
    base_t                  pe_a_q,       pe_a_d;
    logic [2*NUM_PE-1:0]    pe_b_q,       pe_b_d;

    logic                   tmo_hit;

`ifdef SW_STRIPE_TIMEOUT_EN
    logic                   error_q,      error_d;
    logic [TMO_W-1:0]       tmo_q,        tmo_d;

    assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        max_score_d  = max_score_q;
        max_stripe_d = max_stripe_q;
        k_d          = k_q;
        start_pos_d  = start_pos_q;
        a_ptr_d      = a_ptr_q;
        v1_d         = 1'b0;
        // The pipe advances every cycle; a flush overrides this below.
        pe_start_d   = v1_q;
        pe_a_d       = i_a_data;
        pe_b_d       = pe_b_q;
`ifdef SW_STRIPE_TIMEOUT_EN
        error_d      = error_q;
        tmo_d        = tmo_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (i_go) begin
                    max_score_d  = '0;
                    max_stripe_d = '0;
`ifdef SW_STRIPE_TIMEOUT_EN
                    error_d      = 1'b0;
`endif
                    k_d          = '0;
                    start_pos_d  = '0;
                    busy_d       = 1'b1;
                    state_d      = ST_LOAD_B;
                end
            end

            // o_b_addr follows k_q, so the row read is issued here and its
            // data is available during SETTLE.
            ST_LOAD_B: begin
                state_d = ST_SETTLE;
            end

            ST_SETTLE: begin
                pe_b_d  = i_b_data;
                a_ptr_d = start_pos_q[9:0];
`ifdef SW_STRIPE_TIMEOUT_EN
                tmo_d   = '0;
`endif
                state_d = ST_STREAM;
            end

            ST_STREAM, ST_WAIT_END: begin
                if (i_pe_stripe_end) begin
                    // Stripe-end takes priority over the last-address exit:
                    // every read still in flight belongs to the old stripe
                    // and is dropped by clearing both pipe stages.
                    v1_d        = 1'b0;
                    pe_start_d  = 1'b0;
                    start_pos_d = sat_add(start_pos_q, i_pe_start_pos);
                    // Strict compare: on equal scores the earlier stripe
                    // keeps the record.
                    if (i_pe_max_score > max_score_q) begin
                        max_score_d  = i_pe_max_score;
                        max_stripe_d = k_q;
                    end
                    state_d     = ST_NEXT;
                end else if (tmo_hit) begin
`ifdef SW_STRIPE_TIMEOUT_EN
                    error_d     = 1'b1;
`endif
                    v1_d        = 1'b0;
                    pe_start_d  = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_DONE;
                end else begin
`ifdef SW_STRIPE_TIMEOUT_EN
                    tmo_d       = tmo_q + 1'b1;
`endif
                    if (state_q == ST_STREAM) begin
                        // o_a_addr = a_ptr_q is the read issued this cycle.
                        v1_d    = 1'b1;
                        a_ptr_d = a_ptr_q + 1'b1;
                        if (a_ptr_q == A_LAST) begin
                            state_d = ST_WAIT_END;
                        end
                    end
                end
            end

            ST_NEXT: begin
                k_d = k_q + 1'b1;
                if ((k_q == K_LAST) || (start_pos_q == SPOS_END)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_LOAD_B;
                end
            end

            // done_q is high for exactly this cycle; results stay held.
            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            max_score_q  <= '0;
            max_stripe_q <= '0;
            k_q          <= '0;
            start_pos_q  <= '0;
            a_ptr_q      <= '0;
            v1_q         <= 1'b0;
            pe_start_q   <= 1'b0;
            pe_a_q       <= '0;
            pe_b_q       <= '0;
`ifdef SW_STRIPE_TIMEOUT_EN
            error_q      <= 1'b0;
            tmo_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            max_score_q  <= max_score_d;
            max_stripe_q <= max_stripe_d;
            k_q          <= k_d;
            start_pos_q  <= start_pos_d;
            a_ptr_q      <= a_ptr_d;
            v1_q         <= v1_d;
            pe_start_q   <= pe_start_d;
            pe_a_q       <= pe_a_d;
            pe_b_q       <= pe_b_d;
`ifdef SW_STRIPE_TIMEOUT_EN
            error_q      <= error_d;
            tmo_q        <= tmo_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Outputs (all straight from flops)
    // -----------------------------------------------------------------------
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_max_score  = max_score_q;
    assign o_max_stripe = max_stripe_q;
    assign o_a_addr     = a_ptr_q;
    assign o_b_addr     = k_q;
    assign o_pe_start   = pe_start_q;
    assign o_pe_a       = pe_a_q;
    assign o_pe_b       = pe_b_q;
    assign o_dbg_state  = state_q;

`ifdef SW_STRIPE_TIMEOUT_EN
    assign o_error      = error_q;
`else
    assign o_error      = 1'b0;
`endif

endmodule

// File: tb/tb_sw_stripe_sequencer.sv
// Directed bench for sw_stripe_sequencer: external A/B memories and a
// scripted array model, with hand-computed expectations per stripe.
module tb_sw_stripe_sequencer;
  import sw_pkg::*;

  // ---------------- clock / reset ----------------
  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  logic         i_go = 1'b0;
  logic         o_busy, o_done, o_error, o_pe_start;
  logic [13:0]  o_max_score;
  logic [3:0]   o_max_stripe, o_b_addr;
  logic [9:0]   o_a_addr;
  logic [1:0]   a_data = '0;
  logic [127:0] b_data = '0;
  logic [1:0]   o_pe_a;
  logic [127:0] o_pe_b;
  logic         i_pe_stripe_end = 1'b0;
  logic [9:0]   i_pe_start_pos = '0;
  logic [13:0]  i_pe_max_score = '0;
  logic [2:0]   o_dbg_state;

  sw_stripe_sequencer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_go(i_go),
    .o_busy(o_busy), .o_done(o_done),
    .o_max_score(o_max_score), .o_max_stripe(o_max_stripe), .o_error(o_error),
    .o_a_addr(o_a_addr), .i_a_data(a_data),
    .o_b_addr(o_b_addr), .i_b_data(b_data),
    .o_pe_start(o_pe_start), .o_pe_a(o_pe_a), .o_pe_b(o_pe_b),
    .i_pe_stripe_end(i_pe_stripe_end), .i_pe_start_pos(i_pe_start_pos),
    .i_pe_max_score(i_pe_max_score), .o_dbg_state(o_dbg_state)
  );

  // ---------------- memory models (1-cycle sync read) ----------------
  function automatic logic [1:0] amem(input int a);
    logic [9:0] x;
    x = a[9:0];
    return x[1:0] ^ x[4:3];
  endfunction

  function automatic logic [127:0] brow(input int k);
    logic [127:0] r;
    for (int n = 0; n < 64; n++) r[2*n +: 2] = 2'(n + 3 * k);
    return r;
  endfunction

  always @(posedge i_clk) begin
    a_data <= amem(int'(o_a_addr));
    b_data <= brow(int'(o_b_addr));
  end

  int done_cnt = 0;
  always @(negedge i_clk) if (o_done === 1'b1) done_cnt <= done_cnt + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_state(input logic [2:0] st, input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      if (o_dbg_state == st) break;
      @(negedge i_clk);
    end
    check(tag, o_dbg_state, st);
  endtask

  task automatic start_run();
    i_go = 1'b1;
    @(negedge i_clk);
    i_go = 1'b0;
    check("go_busy", o_busy, 1);
    check("go_state", o_dbg_state, ST_LOAD_B);
    check("go_max_clr", o_max_score, 0);
    check("go_stripe_clr", o_max_stripe, 0);
  endtask

  // One stripe: the array model lets `len` cycles pass from the first
  // possible start, then pulses stripe-end with (rel, score).
  task automatic do_stripe(input int k, input int start, input int len,
                           input int rel, input int score, input bit last);
    int rem, n_start, bad_a, exp_n;
    logic [2:0] st_exp;
    wait_state(ST_SETTLE, 50, "wait_settle");
    @(negedge i_clk);
    check("first_addr", o_a_addr, start);
    check("pe_b_row", o_pe_b, brow(k));
    check("start_low1", o_pe_start, 0);
    @(negedge i_clk);
    check("start_low2", o_pe_start, 0);
    rem = 1024 - start;
    n_start = 0;
    bad_a = 0;
    for (int i = 0; i < len; i++) begin
      @(negedge i_clk);
      if (o_pe_start === 1'b1) begin
        if (o_pe_a !== amem(start + n_start)) bad_a++;
        n_start++;
      end
    end
    st_exp = (len + 2 > rem) ? ST_WAIT_END : ST_STREAM;
    exp_n = (len < rem) ? len : rem;
    check("end_state", o_dbg_state, st_exp);
    check("start_count", n_start, exp_n);
    check("a_bases", bad_a, 0);
    i_pe_stripe_end = 1'b1;
    i_pe_start_pos  = 10'(rel);
    i_pe_max_score  = 14'(score);
    @(negedge i_clk);
    i_pe_stripe_end = 1'b0;
    check("next_state", o_dbg_state, ST_NEXT);
    check("flush", o_pe_start, 0);
    @(negedge i_clk);
    check("after_next", o_dbg_state, last ? ST_DONE : ST_LOAD_B);
    if (last) begin
      check("done_pulse", o_done, 1);
      check("done_busy", o_busy, 0);
    end
  endtask

  // Stripe tables: start addresses and running max are hand-computed.
  int n_str;
  int start_t[4], len_t[4], rel_t[4], score_t_[4], max_t[4];

  task automatic run_table(input int exp_max, input int exp_stripe, input bit poke_go);
    int d0;
    d0 = done_cnt;
    start_run();
    for (int k = 0; k < n_str; k++) begin
      do_stripe(k, start_t[k], len_t[k], rel_t[k], score_t_[k], k == n_str - 1);
      check("run_max", o_max_score, max_t[k]);
      if (poke_go && k == 0) begin
        // go while busy must not restart or clear anything
        i_go = 1'b1;
        @(negedge i_clk);
        i_go = 1'b0;
      end
    end
    @(negedge i_clk);
    check("idle_after", o_dbg_state, ST_IDLE);
    @(negedge i_clk);
    check("final_max", o_max_score, exp_max);
    check("final_stripe", o_max_stripe, exp_stripe);
    check("done_once", done_cnt - d0, 1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    repeat (2) @(negedge i_clk);
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_state", o_dbg_state, ST_IDLE);
    check("rst_pe_start", o_pe_start, 0);
    check("rst_max", o_max_score, 0);
    check("rst_addr", o_a_addr, 0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Basic stripe, accumulation 0/40/140/340, ties 30/50/50/10, saturating exit.
    n_str = 4;
    start_t  = '{0, 40, 140, 340};
    len_t    = '{5, 4, 6, 3};
    rel_t    = '{40, 100, 200, 700};
    score_t_ = '{30, 50, 50, 10};
    max_t    = '{30, 50, 50, 50};
    run_table(50, 1, 1'b1);

    // End of A: start 1000, stripe-end only after address 1023 (WAIT_END),
    // then relative 100 saturates to 1024 and the run ends.
    n_str = 2;
    start_t  = '{0, 1000, 0, 0};
    len_t    = '{3, 30, 0, 0};
    rel_t    = '{1000, 100, 0, 0};
    score_t_ = '{5, 7, 0, 0};
    max_t    = '{5, 7, 0, 0};
    run_table(7, 1, 1'b0);

    // Stripe-end coinciding with the last address (1023): no WAIT_END.
    n_str = 3;
    start_t  = '{0, 1000, 1005, 0};
    len_t    = '{3, 22, 3, 0};
    rel_t    = '{1000, 5, 100, 0};
    score_t_ = '{9, 4, 9, 0};
    max_t    = '{9, 9, 9, 0};
    run_table(9, 0, 1'b0);

    // Reset mid-STREAM clears everything asynchronously.
    start_run();
    wait_state(ST_STREAM, 20, "wait_stream");
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_state", o_dbg_state, ST_IDLE);
    check("arst_busy", o_busy, 0);
    check("arst_start", o_pe_start, 0);
    check("arst_max", o_max_score, 0);
    check("arst_b", o_pe_b, 0);
    check("arst_error", o_error, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    check("arst_hold", o_dbg_state, ST_IDLE);

`ifdef SW_STRIPE_TIMEOUT_EN
    start_run();
    wait_state(ST_STREAM, 20, "wd_stream");
    for (int i = 0; i < 400; i++) begin
      if (o_done === 1'b1) break;
      @(negedge i_clk);
    end
    check("wd_done", o_done, 1);
    check("wd_error", o_error, 1);
    check("wd_busy", o_busy, 0);
    @(negedge i_clk);
    check("wd_idle", o_dbg_state, ST_IDLE);
    check("wd_sticky", o_error, 1);
`else
    check("error_tied", o_error, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench can never hang.
  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

endmodule
